serial_mag_cmp: RTL



---
 rtl/serial_mag_cmp_pkg.sv | 24 ++
 rtl/serial_mag_cmp_slice4.sv | 18 +
 rtl/serial_mag_cmp.sv | 97 +++++++++
 3 files changed

// File: rtl/serial_mag_cmp_pkg.sv
// Shared definitions for the serial magnitude comparator.
// Holds the one-hot cascade codes, the FSM state type and the cascade normaliser.
package serial_mag_cmp_pkg;

  localparam logic [2:0] CMP_GT = 3'b100;
  localparam logic [2:0] CMP_EQ = 3'b010;
  localparam logic [2:0] CMP_LT = 3'b001;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Any cascade value that is not exactly one-hot is treated as "equal so far".
  function automatic logic [2:0] norm_cascade(input logic [2:0] c);
    logic [2:0] res;
    unique case (c)
      CMP_GT, CMP_EQ, CMP_LT: res = c;
      default:                res = CMP_EQ;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/serial_mag_cmp_slice4.sv
// One 4-bit cascaded magnitude comparator slice.
// An unequal nibble overrides the cascade; equal nibbles pass it through.
module mag_slice4
  import serial_mag_cmp_pkg::*;
(
  input  logic [3:0] x,
  input  logic [3:0] y,
  input  logic [2:0] casc_in,
  output logic [2:0] casc_out
);

  always_comb begin
    casc_out = casc_in;
    if (x > y)      casc_out = CMP_GT;
    else if (x < y) casc_out = CMP_LT;
  end

endmodule

// File: rtl/serial_mag_cmp.sv
// Sequential unsigned magnitude comparator that reuses one 4-bit slice
// over WIDTH/4 cycles, LSB nibble first, feeding its own cascade back.
//
// state | meaning
// IDLE  | waiting for start; y holds the last result
// RUN   | one nibble per cycle, LSB first; last nibble publishes y and done
module serial_mag_cmp
  import serial_mag_cmp_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       cin,
  output logic             busy,
  output logic             done,
  output logic [2:0]       y
);

  localparam int NSL   = WIDTH / 4;
  localparam int IDX_W = (NSL > 1) ? $clog2(NSL) : 1;

  if (((WIDTH % 4) != 0) || (WIDTH < 4)) begin : g_bad_width
    $error("serial_mag_cmp: WIDTH must be a multiple of 4 and at least 4");
  end

  state_t           state;
  state_t           state_nxt;
  logic [IDX_W-1:0] idx;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [2:0]       casc;
  logic [2:0]       casc_nxt;
  logic             accept;
  logic             last;

  mag_slice4 u_slice (
    .x        (a_sh[3:0]),
    .y        (b_sh[3:0]),
    .casc_in  (casc),
    .casc_out (casc_nxt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (last)  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy   = (state == RUN);
    accept = (state == IDLE) && start;
    last   = (state == RUN) && (idx == IDX_W'(NSL - 1));
  end

  // Operands shift right so the active nibble is always at bits [3:0].
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx  <= '0;
      a_sh <= '0;
      b_sh <= '0;
      casc <= CMP_EQ;
      y    <= 3'b000;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      if (accept) begin
        a_sh <= a;
        b_sh <= b;
        idx  <= '0;
        casc <= norm_cascade(cin);
      end else if (state == RUN) begin
        a_sh <= a_sh >> 4;
        b_sh <= b_sh >> 4;
        casc <= casc_nxt;
        idx  <= idx + 1'b1;
        if (last) begin
          y    <= casc_nxt;
          done <= 1'b1;
          idx  <= '0;
        end
      end
    end
  end

endmodule
